single_cycle_proc: RTL and testbench



---
 rtl/single_cycle_proc.sv | 243 ++++++++++++++++++++++++
 tb/tb_single_cycle_proc.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/single_cycle_proc.sv
// Single-cycle 64-bit LEGv8 core with internal instruction ROM, 32x64 register
// file, ALU and 64-doubleword data RAM. Every instruction completes in one CLK.
module single_cycle_proc (
    input  logic        CLK,
    input  logic        reset,
    input  logic [63:0] startpc,
    output logic [63:0] currentpc,
    output logic [63:0] MemtoRegOut
);

    typedef enum logic [3:0] {
        OP_NOP, OP_LDUR, OP_STUR, OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_CBZ, OP_B, OP_MOVZ
    } op_e;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR, ALU_PASSB
    } alu_e;

    // Program ROM: two demo programs, everything else reads as a zero word (no-op)
    function automatic logic [31:0] rom_word(input logic [5:0] idx);
        logic [31:0] w;
        case (idx)
            6'd0:    w = 32'hF84003E9; // LDUR X9,  [XZR,#0x00]
            6'd1:    w = 32'hF84083EA; // LDUR X10, [XZR,#0x08]
            6'd2:    w = 32'hF84103EB; // LDUR X11, [XZR,#0x10]
            6'd3:    w = 32'hF84183EC; // LDUR X12, [XZR,#0x18]
            6'd4:    w = 32'hF84203ED; // LDUR X13, [XZR,#0x20]
            6'd5:    w = 32'hAA0B014A; // ORR  X10, X10, X11
            6'd6:    w = 32'h8A0A018C; // AND  X12, X12, X10
            6'd7:    w = 32'hB4000089; // CBZ  X9, +4
            6'd8:    w = 32'h8B0C01AD; // ADD  X13, X13, X12
            6'd9:    w = 32'hCB090129; // SUB  X9, X9, X9
            6'd10:   w = 32'h17FFFFFD; // B    -3
            6'd11:   w = 32'hF80203ED; // STUR X13, [XZR,#0x20]
            6'd12:   w = 32'hF84203ED; // LDUR X13, [XZR,#0x20]
            6'd13:   w = 32'hD2E24689; // MOVZ X9,  #0x1234, LSL 48
            6'd14:   w = 32'hD2CACF0A; // MOVZ X10, #0x5678, LSL 32
            6'd15:   w = 32'hAA0A0129; // ORR  X9, X9, X10
            6'd16:   w = 32'hD2B3578A; // MOVZ X10, #0x9ABC, LSL 16
            6'd17:   w = 32'hAA0A0129; // ORR  X9, X9, X10
            6'd18:   w = 32'hD29BDE0A; // MOVZ X10, #0xDEF0
            6'd19:   w = 32'hAA0A0129; // ORR  X9, X9, X10
            6'd20:   w = 32'hF80283E9; // STUR X9,  [XZR,#0x28]
            6'd21:   w = 32'hF84283EA; // LDUR X10, [XZR,#0x28]
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    logic [63:0] pc_r;
    logic        hold_r;
    logic [31:0] instr_s;
    op_e         op_s;
    alu_e        alu_ctl_s;
    logic        reg2loc_s;
    logic        alu_src_s;
    logic        mem_to_reg_s;
    logic        reg_write_s;
    logic        mem_write_s;
    logic        branch_s;
    logic        uncond_s;
    logic [4:0]  rn_s;
    logic [4:0]  rm_s;
    logic [4:0]  rt_s;
    logic [4:0]  rb_s;
    logic [63:0] rd1_s;
    logic [63:0] rd2_s;
    logic [63:0] imm_s;
    logic [63:0] alu_b_s;
    logic [63:0] alu_res_s;
    logic        zero_s;
    logic [63:0] mem_rd_s;
    logic [63:0] wb_s;
    logic [63:0] br_off_s;
    logic [63:0] next_pc_s;

    logic [63:0] regs_r [0:31];
    logic [63:0] dmem_r [0:63] = '{
        0: 64'h0000_0000_0000_0001,
        1: 64'h0000_0000_0000_000A,
        2: 64'h0000_0000_0000_0005,
        3: 64'h0FFB_EA7D_EADB_EEFF,
        default: 64'h0000_0000_0000_0000
    };

    // PC register; hold_r keeps startpc visible from reset release until the first edge
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            pc_r   <= 64'd0;
            hold_r <= 1'b1;
        end else begin
            pc_r   <= next_pc_s;
            hold_r <= 1'b0;
        end
    end

    assign currentpc = (reset || hold_r) ? startpc : pc_r;
    assign instr_s   = rom_word(currentpc[7:2]);
    assign rn_s      = instr_s[9:5];
    assign rm_s      = instr_s[20:16];
    assign rt_s      = instr_s[4:0];

    // Opcode decode in priority order: 11-bit opcodes, then CBZ, B, MOVZ
    always_comb begin
        op_s = OP_NOP;
        if (instr_s[31:21] == 11'h7C2) begin
            op_s = OP_LDUR;
        end else if (instr_s[31:21] == 11'h7C0) begin
            op_s = OP_STUR;
        end else if (instr_s[31:21] == 11'h458) begin
            op_s = OP_ADD;
        end else if (instr_s[31:21] == 11'h658) begin
            op_s = OP_SUB;
        end else if (instr_s[31:21] == 11'h450) begin
            op_s = OP_AND;
        end else if (instr_s[31:21] == 11'h550) begin
            op_s = OP_ORR;
        end else if (instr_s[31:24] == 8'hB4) begin
            op_s = OP_CBZ;
        end else if (instr_s[31:26] == 6'h05) begin
            op_s = OP_B;
        end else if (instr_s[31:23] == 9'h1A5) begin
            op_s = OP_MOVZ;
        end else begin
            op_s = OP_NOP;
        end
    end

    // Main control signals per instruction class
    always_comb begin
        reg2loc_s    = 1'b0;
        alu_src_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        reg_write_s  = 1'b0;
        mem_write_s  = 1'b0;
        branch_s     = 1'b0;
        uncond_s     = 1'b0;
        alu_ctl_s    = ALU_ADD;
        case (op_s)
            OP_LDUR: begin
                alu_src_s    = 1'b1;
                mem_to_reg_s = 1'b1;
                reg_write_s  = 1'b1;
            end
            OP_STUR: begin
                reg2loc_s   = 1'b1;
                alu_src_s   = 1'b1;
                mem_write_s = 1'b1;
            end
            OP_ADD: reg_write_s = 1'b1;
            OP_SUB: begin
                reg_write_s = 1'b1;
                alu_ctl_s   = ALU_SUB;
            end
            OP_AND: begin
                reg_write_s = 1'b1;
                alu_ctl_s   = ALU_AND;
            end
            OP_ORR: begin
                reg_write_s = 1'b1;
                alu_ctl_s   = ALU_ORR;
            end
            OP_CBZ: begin
                reg2loc_s = 1'b1;
                branch_s  = 1'b1;
                alu_ctl_s = ALU_PASSB;
            end
            OP_B: uncond_s = 1'b1;
            OP_MOVZ: begin
                alu_src_s   = 1'b1;
                reg_write_s = 1'b1;
                alu_ctl_s   = ALU_PASSB;
            end
            default: begin
                reg_write_s = 1'b0;
                mem_write_s = 1'b0;
            end
        endcase
    end

    // Register-file reads; X31 always reads as zero
    always_comb begin
        rb_s  = reg2loc_s ? rt_s : rm_s;
        rd1_s = (rn_s == 5'd31) ? 64'd0 : regs_r[rn_s];
        rd2_s = (rb_s == 5'd31) ? 64'd0 : regs_r[rb_s];
    end

    // Immediate generation: signed load/store offset or shifted MOVZ constant
    always_comb begin
        case (op_s)
            OP_LDUR, OP_STUR: imm_s = {{55{instr_s[20]}}, instr_s[20:12]};
            OP_MOVZ:          imm_s = {48'd0, instr_s[20:5]} << {instr_s[22:21], 4'b0000};
            default:          imm_s = 64'd0;
        endcase
    end

    // ALU; PASSB forwards the second operand (CBZ test value, MOVZ constant)
    always_comb begin
        alu_b_s = alu_src_s ? imm_s : rd2_s;
        case (alu_ctl_s)
            ALU_ADD:   alu_res_s = rd1_s + alu_b_s;
            ALU_SUB:   alu_res_s = rd1_s - alu_b_s;
            ALU_AND:   alu_res_s = rd1_s & alu_b_s;
            ALU_ORR:   alu_res_s = rd1_s | alu_b_s;
            ALU_PASSB: alu_res_s = alu_b_s;
            default:   alu_res_s = 64'd0;
        endcase
        zero_s = (alu_res_s == 64'd0);
    end

    // Data read, write-back select and next-PC selection
    always_comb begin
        mem_rd_s = dmem_r[alu_res_s[8:3]];
        wb_s     = mem_to_reg_s ? mem_rd_s : alu_res_s;
        if (uncond_s) begin
            br_off_s = {{36{instr_s[25]}}, instr_s[25:0], 2'b00};
        end else begin
            br_off_s = {{43{instr_s[23]}}, instr_s[23:5], 2'b00};
        end
        if (uncond_s || (branch_s && zero_s)) begin
            next_pc_s = currentpc + br_off_s;
        end else begin
            next_pc_s = currentpc + 64'd4;
        end
    end

    assign MemtoRegOut = wb_s;

    // Register-file write port; no writes while reset is high, X31 discarded
    always_ff @(posedge CLK) begin
        if (!reset && reg_write_s && (rt_s != 5'd31)) begin
            regs_r[rt_s] <= wb_s;
        end
    end

    // Data RAM write port; contents are retained across reset
    always_ff @(posedge CLK) begin
        if (!reset && mem_write_s) begin
            dmem_r[alu_res_s[8:3]] <= rd2_s;
        end
    end

endmodule

// File: tb/tb_single_cycle_proc.sv
// Bench for single_cycle_proc: an instruction-level reference model (program held
// as an assembly table) predicts PC and write-back every cycle; a monitor
// compares those predictions against the core on the falling clock edge.
module tb_single_cycle_proc;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] startpc = 64'd0;
    logic [63:0] currentpc;
    logic [63:0] MemtoRegOut;

    single_cycle_proc dut (
        .CLK         (CLK),
        .reset       (reset),
        .startpc     (startpc),
        .currentpc   (currentpc),
        .MemtoRegOut (MemtoRegOut)
    );

    always #5 CLK = ~CLK;

    typedef enum logic [3:0] {
        K_NOP, K_LDUR, K_STUR, K_ADD, K_SUB, K_AND, K_ORR, K_CBZ, K_B, K_MOVZ
    } kind_e;

    typedef struct {
        kind_e  kind;
        int     d;
        int     n;
        int     m;
        longint imm;
        int     hw;
    } ins_t;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] out;
        bit          out_chk;
        bit          spot_en;
        logic [63:0] spot_val;
    } exp_t;

    ins_t        prog [64];
    logic [63:0] xreg [32];
    bit          xvalid [32];
    logic [63:0] dmem [64];
    logic [63:0] m_pc;
    exp_t        sb [$];
    int          total = 0;
    int          bad = 0;

    task automatic put(input int idx, input kind_e k, input int d, input int n,
                       input int m, input longint imm, input int hw);
        prog[idx].kind = k;
        prog[idx].d    = d;
        prog[idx].n    = n;
        prog[idx].m    = m;
        prog[idx].imm  = imm;
        prog[idx].hw   = hw;
    endtask

    task automatic load_model();
        for (int i = 0; i < 64; i++) begin
            put(i, K_NOP, 0, 0, 0, 0, 0);
            dmem[i] = 64'd0;
        end
        for (int i = 0; i < 32; i++) begin
            xreg[i]   = 64'd0;
            xvalid[i] = 1'b0;
        end
        dmem[0] = 64'h1;
        dmem[1] = 64'hA;
        dmem[2] = 64'h5;
        dmem[3] = 64'h0FFBEA7DEADBEEFF;
        put(0,  K_LDUR,  9, 31,  0,  0, 0);
        put(1,  K_LDUR, 10, 31,  0,  8, 0);
        put(2,  K_LDUR, 11, 31,  0, 16, 0);
        put(3,  K_LDUR, 12, 31,  0, 24, 0);
        put(4,  K_LDUR, 13, 31,  0, 32, 0);
        put(5,  K_ORR,  10, 10, 11,  0, 0);
        put(6,  K_AND,  12, 12, 10,  0, 0);
        put(7,  K_CBZ,   9,  0,  0,  4, 0);
        put(8,  K_ADD,  13, 13, 12,  0, 0);
        put(9,  K_SUB,   9,  9,  9,  0, 0);
        put(10, K_B,     0,  0,  0, -3, 0);
        put(11, K_STUR, 13, 31,  0, 32, 0);
        put(12, K_LDUR, 13, 31,  0, 32, 0);
        put(13, K_MOVZ,  9,  0,  0, 64'h1234, 3);
        put(14, K_MOVZ, 10,  0,  0, 64'h5678, 2);
        put(15, K_ORR,   9,  9, 10,  0, 0);
        put(16, K_MOVZ, 10,  0,  0, 64'h9ABC, 1);
        put(17, K_ORR,   9,  9, 10,  0, 0);
        put(18, K_MOVZ, 10,  0,  0, 64'hDEF0, 0);
        put(19, K_ORR,   9,  9, 10,  0, 0);
        put(20, K_STUR,  9, 31,  0, 40, 0);
        put(21, K_LDUR, 10, 31,  0, 40, 0);
    endtask

    function automatic logic [63:0] rv(input int r);
        return (r == 31) ? 64'd0 : xreg[r];
    endfunction

    function automatic bit vv(input int r);
        return (r == 31) || xvalid[r];
    endfunction

    // Evaluate the instruction at m_pc; with commit, apply its effects
    task automatic model_exec(input bit commit, output logic [63:0] out, output bit chk);
        ins_t        ins;
        logic [63:0] nxt;
        logic [63:0] addr;
        int          wr;
        ins  = prog[m_pc[7:2]];
        nxt  = m_pc + 64'd4;
        out  = 64'd0;
        chk  = 1'b0;
        wr   = -1;
        addr = 64'd0;
        case (ins.kind)
            K_LDUR: begin
                addr = rv(ins.n) + ins.imm;
                out  = dmem[addr[8:3]];
                chk  = vv(ins.n);
                wr   = ins.d;
            end
            K_STUR: begin
                addr = rv(ins.n) + ins.imm;
                if (commit) dmem[addr[8:3]] = rv(ins.d);
            end
            K_ADD: begin out = rv(ins.n) + rv(ins.m); chk = vv(ins.n) && vv(ins.m); wr = ins.d; end
            K_SUB: begin out = rv(ins.n) - rv(ins.m); chk = vv(ins.n) && vv(ins.m); wr = ins.d; end
            K_AND: begin out = rv(ins.n) & rv(ins.m); chk = vv(ins.n) && vv(ins.m); wr = ins.d; end
            K_ORR: begin out = rv(ins.n) | rv(ins.m); chk = vv(ins.n) && vv(ins.m); wr = ins.d; end
            K_CBZ: if (rv(ins.d) == 64'd0) nxt = m_pc + (ins.imm * 4);
            K_B:   nxt = m_pc + (ins.imm * 4);
            K_MOVZ: begin
                out = 64'(ins.imm) << (16 * ins.hw);
                chk = 1'b1;
                wr  = ins.d;
            end
            default: ;
        endcase
        if (commit) begin
            if (wr >= 0 && wr != 31) begin
                xreg[wr]   = out;
                xvalid[wr] = chk;
            end
            m_pc = nxt;
        end
    endtask

    // One clock: advance the model past the edge, drive inputs, queue the expectation
    task automatic step(input bit rst_v, input logic [63:0] sp_v, input bit mid,
                        input logic [63:0] tgt, input logic [63:0] tval,
                        input bit spot, output bit hit);
        exp_t        e;
        logic [63:0] o;
        bit          c;
        bit          rst_at_edge;
        @(posedge CLK);
        #1;
        rst_at_edge = reset;
        if (rst_at_edge) m_pc = startpc;
        else model_exec(1'b1, o, c);
        hit = 1'b0;
        e.spot_en  = 1'b0;
        e.spot_val = 64'd0;
        if (mid) begin
            #2;
            reset     = 1'b1;
            startpc   = sp_v;
            m_pc      = sp_v;
            e.pc      = sp_v;
            e.out     = 64'd0;
            e.out_chk = 1'b0;
        end else begin
            reset   = rst_v;
            startpc = sp_v;
            if (rst_at_edge || rst_v) m_pc = sp_v;
            model_exec(1'b0, o, c);
            e.pc      = m_pc;
            e.out     = o;
            e.out_chk = c && !rst_v;
            if (spot && !rst_v && (m_pc == tgt)) begin
                e.spot_en  = 1'b1;
                e.spot_val = tval;
                hit        = 1'b1;
            end
        end
        sb.push_back(e);
    endtask

    task automatic do_reset(input logic [63:0] sp, input int edges);
        bit h;
        for (int i = 0; i < edges; i++) step(1'b1, sp, 1'b0, 64'd0, 64'd0, 1'b0, h);
    endtask

    task automatic run(input int n);
        bit h;
        for (int i = 0; i < n; i++) step(1'b0, startpc, 1'b0, 64'd0, 64'd0, 1'b0, h);
    endtask

    task automatic run_until(input logic [63:0] tgt, input logic [63:0] val, input int budget);
        bit h;
        int k;
        h = 1'b0;
        k = 0;
        while (!h && k < budget) begin
            step(1'b0, startpc, 1'b0, tgt, val, 1'b1, h);
            k++;
        end
        if (!h) begin
            total++;
            bad++;
            $display("FAIL reach_pc target=%h not reached, model_pc=%h", tgt, m_pc);
        end
    endtask

    // Monitor: compare the core against the oldest queued expectation
    always @(negedge CLK) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if (currentpc !== e.pc) begin
                bad++;
                $display("FAIL pc got=%h want=%h", currentpc, e.pc);
            end
            if (e.out_chk) begin
                total++;
                if (MemtoRegOut !== e.out) begin
                    bad++;
                    $display("FAIL wb pc=%h got=%h want=%h", e.pc, MemtoRegOut, e.out);
                end
            end
            if (e.spot_en) begin
                total++;
                if (MemtoRegOut !== e.spot_val) begin
                    bad++;
                    $display("FAIL spot pc=%h got=%h want=%h", e.pc, MemtoRegOut, e.spot_val);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int          sel;
        int          len;
        logic [63:0] sp;
        bit          h;
        load_model();
        m_pc = 64'd0;

        // program 1
        do_reset(64'h0, 2);
        run_until(64'h00, 64'h1, 3);
        run_until(64'h18, 64'hF, 20);
        run_until(64'h30, 64'hF, 30);

        // program 2
        do_reset(64'h34, 2);
        run_until(64'h34, 64'h1234000000000000, 3);
        run_until(64'h48, 64'h000000000000DEF0, 10);
        run_until(64'h54, 64'h123456789ABCDEF0, 10);

        // data RAM retained across reset
        do_reset(64'h30, 1);
        run_until(64'h30, 64'hF, 3);

        // no register write while reset holds PC on an ADD
        do_reset(64'h20, 3);
        run_until(64'h20, 64'h1E, 3);

        // no memory write while reset holds PC on a STUR (X13 is 0x1E here)
        do_reset(64'h2C, 3);
        do_reset(64'h30, 1);
        run_until(64'h30, 64'hF, 3);

        // asynchronous reset in the middle of a cycle
        do_reset(64'h34, 1);
        run(3);
        step(1'b0, 64'h48, 1'b1, 64'd0, 64'd0, 1'b0, h);
        run_until(64'h48, 64'h000000000000DEF0, 3);

        // PC wraps from the top of the address space into program 1
        do_reset(64'hFFFF_FFFF_FFFF_FFF8, 1);
        run_until(64'h0, 64'h1, 5);

        // randomized start points, run lengths and mid-cycle resets
        for (int ep = 0; ep < 25; ep++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       sp = 64'h0;
                1:       sp = 64'h34;
                2:       sp = 64'($urandom_range(0, 63)) << 2;
                default: sp = 64'hFFFF_FFFF_FFFF_FF00 | (64'($urandom_range(0, 63)) << 2);
            endcase
            do_reset(sp, $urandom_range(1, 3));
            len = $urandom_range(5, 60);
            run(len);
            if ($urandom_range(0, 1) == 1) begin
                step(1'b0, 64'($urandom_range(0, 63)) << 2, 1'b1, 64'd0, 64'd0, 1'b0, h);
            end
        end

        run(2);
        @(negedge CLK);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
